// File: rtl/mc_sync_bridge_pkg.sv
// mc_sync_bridge_pkg: shared constants, the channel-index type and the
// round-robin search used by the mc_sync_bridge arbiter.
package mc_sync_bridge_pkg;

   localparam int DROP_CNT_W = 8;
   localparam int CHAN_IDX_W = 6;
   localparam int MAX_NCH    = 1 << CHAN_IDX_W;

   typedef logic [CHAN_IDX_W-1:0] chan_idx_t;
   // One bit wider than a channel index so last+offset never overflows.
   typedef logic [CHAN_IDX_W:0]   rr_wide_t;

   // First set bit of req_mask at or after last+1, wrapping at nch.
   // Returns last unchanged when no bit below nch is set.
   function automatic chan_idx_t next_rr(input chan_idx_t              last,
                                         input logic [MAX_NCH-1:0]     req_mask,
                                         input rr_wide_t               nch);
      chan_idx_t grant;
      logic      found;
      rr_wide_t  idx;
      grant = last;
      found = 1'b0;
      for (int k = 1; k <= MAX_NCH; k++) begin
         if (rr_wide_t'(k) <= nch) begin
            idx = {1'b0, last} + rr_wide_t'(k);
            if (idx >= nch) idx = idx - nch;
            if (!found && req_mask[idx[CHAN_IDX_W-1:0]]) begin
               grant = idx[CHAN_IDX_W-1:0];
               found = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/mc_sync_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head, registered count.
// Storage is not reset; only pointers and count are.
module sync_fifo
   import mc_sync_bridge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     resetb,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage write; contents are meaningless until pointed at by a push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mc_sync_bridge.sv
// mc_sync_bridge: NCH same-clock producer channels, each with its own FIFO,
// drained round-robin onto one registered consumer port tagged by channel.
// Optional per-channel drop counters: define MC_SYNC_BRIDGE_DROP_CNT_EN.
module mc_sync_bridge
   import mc_sync_bridge_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int NCH   = 4
) (
   input  logic                        clk,
   input  logic                        resetb,
   input  logic [NCH*WIDTH-1:0]        din,
   input  logic [NCH-1:0]              data_valid,
   output logic [NCH-1:0]              data_req,
   input  logic                        rd_req,
   output logic                        data_valid_out,
   output logic [WIDTH-1:0]            dout,
   output logic [$clog2(NCH)-1:0]      chan_out,
   output logic [NCH*DROP_CNT_W-1:0]   drop_cnt
);

   localparam int CW = $clog2(NCH);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0]   head     [NCH];
   logic [AW:0]        fifo_cnt [NCH];
   logic [NCH-1:0]     fifo_full;
   logic [NCH-1:0]     fifo_empty;
   logic [NCH-1:0]     push;
   logic [NCH-1:0]     pop;
   logic [MAX_NCH-1:0] ne_mask;
   logic               grant_vld;
   logic [CW-1:0]      grant_ch;
   logic [CW-1:0]      last_grant;
   logic               vld_p1;
   logic [WIDTH-1:0]   dout_p1;
   logic [CW-1:0]      chan_p1;
   logic               fifo_full_unused;

   // The arbiter works from occupancy counts; the FIFO's own full flag is spare.
   assign fifo_full_unused = ^fifo_full;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk    (clk),
         .resetb (resetb),
         .push   (push[i]),
         .din    (din[i*WIDTH +: WIDTH]),
         .pop    (pop[i]),
         .dout   (head[i]),
         .count  (fifo_cnt[i]),
         .full   (fifo_full[i]),
         .empty  (fifo_empty[i])
      );
      // Space indication straight from the registered count: a pop this
      // cycle only shows up as space next cycle.
      assign data_req[i] = resetb && (fifo_cnt[i] < (AW+1)'(DEPTH));
   end

   assign push = data_valid & data_req;

   // Non-empty channels, widened to the search function's fixed mask width.
   always_comb begin
      ne_mask          = '0;
      ne_mask[NCH-1:0] = ~fifo_empty;
   end

   assign grant_vld = rd_req && (|(~fifo_empty));
   assign grant_ch  = CW'(next_rr(chan_idx_t'(last_grant), ne_mask, rr_wide_t'(NCH)));

   // One-hot pop for the granted channel.
   always_comb begin
      pop = '0;
      if (grant_vld) pop[grant_ch] = 1'b1;
   end

   // ---- stage p1: registered output word, channel tag and valid pulse ----
   always_ff @(posedge clk) begin
      if (!resetb) begin
         vld_p1     <= 1'b0;
         dout_p1    <= '0;
         chan_p1    <= '0;
         last_grant <= CW'(NCH-1);
      end else begin
         vld_p1 <= grant_vld;
         if (grant_vld) begin
            dout_p1    <= head[grant_ch];
            chan_p1    <= grant_ch;
            last_grant <= grant_ch;
         end
      end
   end

   assign data_valid_out = vld_p1;
   assign dout           = dout_p1;
   assign chan_out       = chan_p1;

`ifdef MC_SYNC_BRIDGE_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_q [NCH];

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == '1) ? v : v + DROP_CNT_W'(1);
   endfunction

   // Count cycles where a channel offered a word it had no room for.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         for (int i = 0; i < NCH; i++) drop_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (data_valid[i] && !data_req[i]) drop_q[i] <= sat_inc(drop_q[i]);
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_drop
      assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_q[i];
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sync_bridge.sv
// tb_mc_sync_bridge: directed and random stimulus for mc_sync_bridge,
// checked each cycle against a queue-based reference model.
module tb_mc_sync_bridge;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int NCH   = 4;
   localparam int CW    = $clog2(NCH);

   typedef logic [WIDTH-1:0] word_t;

   logic                 clk = 1'b0;
   logic                 resetb;
   logic [NCH*WIDTH-1:0] din;
   logic [NCH-1:0]       data_valid;
   logic [NCH-1:0]       data_req;
   logic                 rd_req;
   logic                 data_valid_out;
   logic [WIDTH-1:0]     dout;
   logic [CW-1:0]        chan_out;
   logic [NCH*8-1:0]     drop_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: one queue per channel plus the last granted channel.
   word_t mq [NCH][$];
   int    m_last = NCH-1;
   logic  m_vld  = 1'b0;
   word_t m_dout = '0;
   int    m_chan = 0;
   int    m_drop [NCH];

   mc_sync_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
      .clk            (clk),
      .resetb         (resetb),
      .din            (din),
      .data_valid     (data_valid),
      .data_req       (data_req),
      .rd_req         (rd_req),
      .data_valid_out (data_valid_out),
      .dout           (dout),
      .chan_out       (chan_out),
      .drop_cnt       (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH-1:0] m_req();
      logic [NCH-1:0] r;
      for (int i = 0; i < NCH; i++) r[i] = resetb && (mq[i].size() < DEPTH);
      return r;
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   function automatic void model_edge();
      logic [NCH-1:0] req;
      int g;
      req = m_req();
      if (!resetb) begin
         for (int i = 0; i < NCH; i++) begin
            mq[i].delete();
            m_drop[i] = 0;
         end
         m_last = NCH-1;
         m_vld  = 1'b0;
         m_dout = '0;
         m_chan = 0;
      end else begin
         g = -1;
         if (rd_req) begin
            for (int k = 1; k <= NCH; k++) begin
               int c;
               c = (m_last + k) % NCH;
               if (g < 0 && mq[c].size() > 0) g = c;
            end
         end
         if (g >= 0) begin
            m_dout = mq[g].pop_front();
            m_chan = g;
            m_vld  = 1'b1;
            m_last = g;
         end else begin
            m_vld = 1'b0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (data_valid[i]) begin
               if (req[i]) mq[i].push_back(din[i*WIDTH +: WIDTH]);
               else if (m_drop[i] < 255) m_drop[i]++;
            end
         end
      end
   endfunction

   // One clock: check data_req before the edge, outputs just after it.
   task automatic step();
      logic [NCH*8-1:0] exp_drop;
      #1;
      check("data_req", 64'(data_req), 64'(m_req()));
      model_edge();
      @(posedge clk);
      #1;
      check("data_valid_out", 64'(data_valid_out), 64'(m_vld));
      check("dout", 64'(dout), 64'(m_dout));
      check("chan_out", 64'(chan_out), 64'(m_chan));
      exp_drop = '0;
`ifdef MC_SYNC_BRIDGE_DROP_CNT_EN
      for (int i = 0; i < NCH; i++) exp_drop[i*8 +: 8] = 8'(m_drop[i]);
`endif
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
   endtask

   task automatic do_reset();
      resetb     = 1'b0;
      data_valid = '0;
      rd_req     = 1'b0;
      step();
      resetb = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NCH; i++) m_drop[i] = 0;
      resetb     = 1'b0;
      din        = '0;
      data_valid = '0;
      rd_req     = 1'b0;
      step();
      step();
      check("reset_valid", 64'(data_valid_out), 64'(0));
      check("reset_dout", 64'(dout), 64'(0));
      resetb = 1'b1;

      // Single word on channel 2, seen two edges after presentation.
      rd_req = 1'b1;
      din[2*WIDTH +: WIDTH] = 8'hA5;
      data_valid = 4'b0100;
      step();
      check("single_not_yet", 64'(data_valid_out), 64'(0));
      data_valid = '0;
      step();
      check("single_valid", 64'(data_valid_out), 64'(1));
      check("single_dout", 64'(dout), 64'(8'hA5));
      check("single_chan", 64'(chan_out), 64'(2));
      check("single_req", 64'(data_req[2]), 64'(1));
      step();
      check("single_pulse", 64'(data_valid_out), 64'(0));

      // Backpressure: five pushes into a four-deep FIFO with no reads.
      rd_req = 1'b0;
      for (int k = 0; k < 5; k++) begin
         din[0 +: WIDTH] = word_t'(8'h10 + k);
         data_valid = 4'b0001;
         step();
         if (k == 3) check("full_req_low", 64'(data_req[0]), 64'(0));
      end
      data_valid = '0;
`ifdef MC_SYNC_BRIDGE_DROP_CNT_EN
      check("full_drop1", 64'(drop_cnt[7:0]), 64'(1));
`endif
      rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("drain_dout", 64'(dout), 64'(8'h10 + k));
         check("drain_valid", 64'(data_valid_out), 64'(1));
         if (k == 0) check("drain_req_back", 64'(data_req[0]), 64'(1));
      end
      step();
      check("drain_done", 64'(data_valid_out), 64'(0));

      // Round robin across all channels, two words each.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NCH; c++) din[c*WIDTH +: WIDTH] = word_t'(c*16 + k);
         data_valid = '1;
         step();
      end
      data_valid = '0;
      rd_req = 1'b1;
      for (int k = 0; k < 2*NCH; k++) begin
         step();
         check("rr_chan", 64'(chan_out), 64'(k % NCH));
         check("rr_dout", 64'(dout), 64'((k % NCH)*16 + k / NCH));
      end
      step();
      check("rr_empty", 64'(data_valid_out), 64'(0));

      // Channel 1 full, concurrent push and pop keeps the output continuous.
      rd_req = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         din[1*WIDTH +: WIDTH] = word_t'(8'h40 + k);
         data_valid = 4'b0010;
         step();
      end
      data_valid = '0;
      rd_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din[1*WIDTH +: WIDTH] = word_t'(8'h50 + k);
         data_valid[1] = (mq[1].size() < DEPTH);
         step();
         check("stream_valid", 64'(data_valid_out), 64'(1));
         if (k < DEPTH) check("stream_order", 64'(dout), 64'(8'h40 + k));
         if (k == 0) check("stream_req_back", 64'(data_req[1]), 64'(1));
      end
      data_valid = '0;
      for (int k = 0; k < DEPTH + 1; k++) step();

      // Reset while three channels hold data, pushes during reset ignored.
      rd_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < NCH; c++) din[c*WIDTH +: WIDTH] = word_t'(8'h60 + c);
         data_valid = 4'b0111;
         step();
      end
      resetb = 1'b0;
      data_valid = '1;
      step();
      check("mid_rst_valid", 64'(data_valid_out), 64'(0));
      resetb = 1'b1;
      data_valid = '0;
      #1;
      check("mid_rst_req", 64'(data_req), 64'(4'hF));
      din[3*WIDTH +: WIDTH] = 8'h7E;
      data_valid = 4'b1000;
      rd_req = 1'b1;
      step();
      data_valid = '0;
      step();
      check("post_rst_valid", 64'(data_valid_out), 64'(1));
      check("post_rst_chan", 64'(chan_out), 64'(3));
      check("post_rst_dout", 64'(dout), 64'(8'h7E));

      // Drop counter saturation on channel 0.
      do_reset();
      din[0 +: WIDTH] = 8'h33;
      data_valid = 4'b0001;
      for (int k = 0; k < DEPTH + 300; k++) step();
      data_valid = '0;
`ifdef MC_SYNC_BRIDGE_DROP_CNT_EN
      check("drop_sat", 64'(drop_cnt[7:0]), 64'(255));
`else
      check("drop_off", 64'(drop_cnt), 64'(0));
`endif

      // Random traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         din        = NCH*WIDTH'($urandom);
         data_valid = NCH'($urandom);
         rd_req     = ($urandom_range(0, 3) != 0);
         resetb     = ($urandom_range(0, 299) != 0);
         step();
      end
      resetb     = 1'b1;
      data_valid = '0;
      rd_req     = 1'b1;
      for (int k = 0; k < NCH*DEPTH + 2; k++) step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mc_sync_bridge.md
# mc_sync_bridge

Single-clock, multi-channel successor to the clka/clkb bridge. It collects words from NCH independent producer channels into per-channel FIFOs. A round-robin arbiter then drains them onto one shared consumer port, tagging each word with its channel index. The block sits wherever several same-clock sources feed one sink that throttles with a level request. Depth, data width and channel count are parameters.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, words per channel FIFO; power of two, ≥2
- NCH, 4, number of producer channels (≥2)

Ports:
- clk  in  1  single clock; all logic on posedge
- resetb  in  1  reset; synchronous, active-low
- din  in  NCH*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
- data_valid  in  NCH  channel i offers din slice this cycle
- data_req  out  NCH  channel i FIFO has space (level); reset 0
- rd_req  in  1  consumer ready for one word this cycle (level)
- data_valid_out  out  1  dout/chan_out hold a word this cycle (one-cycle pulse per word); reset 0
- dout  out  WIDTH  output word; reset 0
- chan_out  out  $clog2(NCH)  source channel of dout; reset 0
- drop_cnt  out  NCH*8  per-channel dropped-word counters; reset 0 (see Configuration)

## Operation
- Push: channel i writes when data_valid[i] & data_req[i]. data_valid[i] while data_req[i]=0 discards the word; FIFO contents are unchanged.
- data_req[i] = (count[i] < DEPTH), decoded from the registered count. No same-cycle bypass: a pop does not raise data_req[i] until the next cycle.
- Arbiter: evaluated each cycle with rd_req=1 and at least one non-empty FIFO.
  - Grants the first non-empty channel searching from last_grant+1, wrapping NCH-1→0.
  - last_grant updates only on a grant.
  - No grant when rd_req=0; all FIFOs hold.
- Pop: on a grant at edge E, the head of channel g is popped. At edge E, dout ← head, chan_out ← g, data_valid_out ← 1.
- Without a grant: data_valid_out ← 0; dout and chan_out hold their last values.
- Per channel, push and pop in the same cycle are both legal, including at full (pop only, since push is blocked) and at empty (push only, since pop needs count>0). The count changes by push−pop.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (resetb=0 at an edge, including mid-transfer):
  - Pointers and counts → 0; stored data is discarded.
  - last_grant → NCH-1, so the first grant after reset goes to channel 0.
  - All outputs → reset values.
  - data_req reads 0 while resetb=0. Any push presented during reset is ignored.

## Timing
- Push at edge E0 → earliest data_valid_out at edge E1 (word visible in the cycle after E1). Minimum latency is 2 edges from the word being presented.
- Throughput: one word per cycle aggregate while rd_req=1 and any FIFO is non-empty. Per-channel sustained rate is 1 word/cycle when it is the only non-empty channel.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,…,NCH-1,0,… with no skips.
- data_req deasserts in the cycle after the push that fills a FIFO. It reasserts in the cycle after the pop that frees a slot.

## Configuration
- MC_SYNC_BRIDGE_DROP_CNT_EN defined:
  - drop_cnt[i*8 +: 8] counts cycles with data_valid[i]=1 & data_req[i]=0.
  - Each counter saturates at 255 and clears only on reset.
- Undefined: no counter logic is built; drop_cnt is tied to 0. Port list unchanged.

## Structure
- Package mc_sync_bridge_pkg:
  - DROP_CNT_W = 8.
  - Typedef for channel index width.
  - Function next_rr(last, req_mask, nch) returning the next grant index.
- Sub-module sync_fifo, instantiated NCH times:
  - Parameters WIDTH, DEPTH.
  - Ports clk, resetb, push, din, pop, dout (combinational head), count, full, empty.
  - Synchronous active-low reset.
- Top-level holds the arbiter, the output register and the optional drop counters.

## Test plan
- Single word: reset, then channel 2 pushes 0xA5 once with rd_req=1 → data_valid_out pulses for one cycle 2 edges later with dout=0xA5, chan_out=2; data_req stays 1.
- Full/backpressure: rd_req=0, channel 0 pushes 5 words (0x10..0x14) with DEPTH=4.
  - data_req[0] drops after the 4th push; the 5th word is discarded.
  - With the macro defined, drop_cnt[7:0]=1.
  - Then rd_req=1 → outputs 0x10..0x13 on consecutive cycles; data_req[0] returns to 1.
- Round-robin: preload 2 words in every channel with rd_req=0, then hold rd_req=1 → chan_out sequence 0,1,2,3,0,1,2,3, then data_valid_out=0.
- Simultaneous push/pop at full: channel 1 full, rd_req=1, only channel 1 occupied → one pop per cycle. data_req[1] returns 1 the cycle after the first pop. Concurrent pushes keep output continuous with no word lost or reordered.
- Mid-operation reset: resetb=0 for one edge while 3 channels hold data → next cycle all counts 0, data_valid_out=0, data_req=0 during reset then all 1. The first new push on channel 3 is granted and output with chan_out=3.
- Drop counter saturation (macro defined): 300 cycles of data_valid[0]=1 with rd_req=0 → drop_cnt[7:0]=255. Without the macro, drop_cnt stays 0.
